// File: rtl/adc_sram_spi_master_if.sv
`default_nettype none
// ------------------------------------------------------------------
// adc_sram_spi_master_if : host command/response and SPI pin bundle
// Revision: 1.0
// ------------------------------------------------------------------
interface adc_sram_spi_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    modport master (
        input  cmd_valid, cmd_read, cmd_data, spi_miso,
        output cmd_ready, rsp_valid, rsp_data, busy,
               spi_cs_n, spi_sclk, spi_mosi
    );

    modport slave (
        output cmd_valid, cmd_read, cmd_data, spi_miso,
        input  cmd_ready, rsp_valid, rsp_data, busy,
               spi_cs_n, spi_sclk, spi_mosi
    );
endinterface
`default_nettype wire

// File: rtl/adc_sram_spi_master.sv
`default_nettype none
// ------------------------------------------------------------------
// adc_sram_spi_master : mode-0 SPI master, 8-bit writes / 32-bit reads
// Revision: 1.0
// ------------------------------------------------------------------
module adc_sram_spi_master #(
    parameter int CLK_DIV  = 3,
    parameter int CS_SETUP = 5,
    parameter int CS_HOLD  = 5,
    parameter int CS_GAP   = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    adc_sram_spi_master_if.master  bus
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [4:0]         bit_cnt, bit_nx;
    logic               rd_q, rd_nx;
    logic [7:0]         data_q, data_nx;
    logic [31:0]        shift_q;
    logic               accept, sample, rsp_load, last_bit, mosi_nx;

    assign last_bit = rd_q ? (bit_cnt == 5'd31) : (bit_cnt == 5'd7);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        bit_nx   = bit_cnt;
        accept   = 1'b0;
        sample   = 1'b0;
        rsp_load = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (bus.cmd_valid && bus.cmd_ready) begin
                    accept   = 1'b1;
                    bit_nx   = '0;
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: if (cnt == CNT_W'(CS_SETUP - 1)) begin
                cnt_nx   = '0;
                state_nx = S_LOW;
            end
            S_LOW: if (cnt == CNT_W'(CLK_DIV - 1)) begin
                cnt_nx   = '0;
                state_nx = S_HIGH;
            end
            S_HIGH: if (cnt == CNT_W'(CLK_DIV - 1)) begin
                cnt_nx = '0;
                sample = rd_q;
                if (last_bit) begin
                    state_nx = S_HOLD;
                end else begin
                    bit_nx   = bit_cnt + 5'd1;
                    state_nx = S_LOW;
                end
            end
            S_HOLD: if (cnt == CNT_W'(CS_HOLD - 1)) begin
                cnt_nx   = '0;
                rsp_load = rd_q;
                state_nx = S_GAP;
            end
            S_GAP: if (cnt == CNT_W'(CS_GAP - 1)) begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase

        rd_nx   = accept ? bus.cmd_read : rd_q;
        data_nx = accept ? bus.cmd_data : data_q;
        // Data bit is held across both sclk phases so it only moves while sclk is low.
        mosi_nx = ((state_nx == S_LOW) || (state_nx == S_HIGH)) && !rd_nx
                  && data_nx[bit_nx[2:0]];
    end

    // Pin and handshake outputs are registered from next-state values to stay glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            rd_q          <= 1'b0;
            data_q        <= '0;
            shift_q       <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_valid <= 1'b0;
            bus.spi_cs_n  <= 1'b1;
            bus.spi_sclk  <= 1'b0;
            bus.spi_mosi  <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_cnt <= bit_nx;
            rd_q    <= rd_nx;
            data_q  <= data_nx;
            if (accept) begin
                shift_q <= '0;
            end else if (sample) begin
                shift_q[bit_cnt] <= bus.spi_miso;
            end
            if (rsp_load) begin
                bus.rsp_data <= shift_q;
            end
            bus.rsp_valid <= rsp_load;
            bus.spi_cs_n  <= (state_nx == S_IDLE) || (state_nx == S_GAP);
            bus.spi_sclk  <= (state_nx == S_HIGH);
            bus.spi_mosi  <= mosi_nx;
            bus.cmd_ready <= (state_nx == S_IDLE);
            bus.busy      <= (state_nx != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_sram_spi_master.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_adc_sram_spi_master : vector table, random frames, slave model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_adc_sram_spi_master;
    localparam int CLK_DIV  = 3;
    localparam int CS_SETUP = 5;
    localparam int CS_HOLD  = 5;
    localparam int CS_GAP   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_sram_spi_master_if bus();

    adc_sram_spi_master #(
        .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Frame monitor, sampled on the falling clk edge.
    logic        mon_prev_cs = 1'b1, mon_prev_sclk = 1'b0, mon_prev_mosi = 1'b0;
    int          mon_low = 0, mon_rises = 0, mon_gap = 0, mon_last_gap = 0, mon_rsp_pulses = 0;
    logic [31:0] mon_cap = '0;
    bit          mon_mosi_seen = 0, mon_hi_change = 0, mon_rsp_at_rise = 0, mon_rb_bad = 0;

    always @(negedge clk) begin
        if (mon_prev_cs && !bus.spi_cs_n) begin
            mon_last_gap    = mon_gap;
            mon_low         = 0;
            mon_rises       = 0;
            mon_cap         = '0;
            mon_mosi_seen   = 0;
            mon_hi_change   = 0;
            mon_rsp_pulses  = 0;
            mon_rsp_at_rise = 0;
        end
        if (!mon_prev_cs && bus.spi_cs_n) mon_rsp_at_rise = bus.rsp_valid;
        if (!bus.spi_cs_n) begin
            mon_low++;
            mon_gap = 0;
        end else begin
            mon_gap++;
        end
        if (!mon_prev_sclk && bus.spi_sclk) begin
            if (mon_rises < 32) mon_cap[5'(mon_rises)] = bus.spi_mosi;
            mon_rises++;
        end
        if (mon_prev_sclk && bus.spi_sclk && (bus.spi_mosi != mon_prev_mosi)) mon_hi_change = 1;
        if (bus.spi_mosi)  mon_mosi_seen = 1;
        if (bus.rsp_valid) mon_rsp_pulses++;
        if (bus.busy == bus.cmd_ready) mon_rb_bad = 1;
        mon_prev_cs   = bus.spi_cs_n;
        mon_prev_sclk = bus.spi_sclk;
        mon_prev_mosi = bus.spi_mosi;
    end

    // Behavioural adc_sram slave: LSB-first word out on MISO, address/data byte pairs in.
    logic [31:0] slave_word = '0;
    bit          slave_mode = 0;
    int          s_idx = 32;
    bit          s_active = 0;
    logic [7:0]  s_sh = '0;
    int          s_n = 0;
    bit          s_expect_addr = 1;
    logic [7:0]  s_addr = '0;
    logic [7:0]  s_regs [256];

    always @(bus.spi_cs_n or negedge bus.spi_sclk) begin
        if (bus.spi_cs_n) s_active = 0;
        else if (!s_active) begin
            s_active = 1;
            s_idx    = 0;
        end else s_idx++;
    end

    assign bus.spi_miso = (s_idx < 32) ? slave_word[s_idx[4:0]] : 1'b0;

    always @(posedge bus.spi_sclk) begin
        if (!bus.spi_cs_n) begin
            if (s_idx == 0) s_n = 0;
            s_sh = {bus.spi_mosi, s_sh[7:1]};
            s_n++;
            if (s_n == 8 && !slave_mode) begin
                if (s_expect_addr) s_addr = s_sh;
                else               s_regs[s_addr] = s_sh;
                s_expect_addr = !s_expect_addr;
            end
        end
    end

    logic [31:0] model_rsp = '0;

    function automatic int frame_len(input bit rd);
        return CS_SETUP + 2 * CLK_DIV * (rd ? 32 : 8) + CS_HOLD;
    endfunction

    task automatic run_cmd(input bit rd, input logic [7:0] data, input logic [31:0] word,
                           input int exp_low, input logic [7:0] exp_byte,
                           input logic [31:0] exp_rsp, input bit hold, input string tag);
        int t;
        t = 0;
        while (!bus.cmd_ready && t < 1000) begin step(); t++; end
        check({tag, " ready_before"}, bus.cmd_ready, 1);
        slave_word    = word;
        slave_mode    = rd;
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = rd;
        bus.cmd_data  = data;
        step();
        if (!hold) bus.cmd_valid = 1'b0;
        t = 0;
        while (!bus.cmd_ready && t < 1000) begin step(); t++; end
        if (rd) model_rsp = exp_rsp;
        check({tag, " cs_low_cycles"}, mon_low, exp_low);
        check({tag, " busy_cycles"}, t, exp_low + CS_GAP);
        check({tag, " sclk_rises"}, mon_rises, rd ? 32 : 8);
        check({tag, " gap_min"}, mon_last_gap >= CS_GAP, 1);
        if (!rd) check({tag, " mosi_byte"}, mon_cap[7:0], exp_byte);
        else     check({tag, " mosi_zero"}, mon_mosi_seen, 0);
        check({tag, " rsp_pulses"}, mon_rsp_pulses, rd ? 1 : 0);
        check({tag, " rsp_at_cs_rise"}, mon_rsp_at_rise, rd);
        check({tag, " rsp_data"}, bus.rsp_data, model_rsp);
        check({tag, " mosi_stable_hi"}, mon_hi_change, 0);
    endtask

    typedef struct {
        bit          rd;
        logic [7:0]  data;
        logic [31:0] word;
        int          exp_low;
        logic [7:0]  exp_byte;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          t;
        bit          rd;
        logic [7:0]  d;
        logic [31:0] w, w2;

        tbl[0] = '{0, 8'h05, 32'h0,         58,  8'h05, 32'h0};
        tbl[1] = '{0, 8'h01, 32'h0,         58,  8'h01, 32'h0};
        tbl[2] = '{1, 8'h3C, 32'hA5C3_0F81, 202, 8'h00, 32'hA5C3_0F81};
        tbl[3] = '{0, 8'h03, 32'h0,         58,  8'h03, 32'h0};
        tbl[4] = '{1, 8'hFF, 32'h8000_0001, 202, 8'h00, 32'h8000_0001};
        tbl[5] = '{0, 8'hA5, 32'h0,         58,  8'hA5, 32'h0};

        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", {bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.cmd_ready,
                                bus.busy, bus.rsp_valid}, 6'b100100);
        check("reset_rsp_data", bus.rsp_data, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", {bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.cmd_ready,
                                   bus.busy, bus.rsp_valid}, 6'b100100);
        end

        for (int i = 0; i < 6; i++)
            run_cmd(tbl[i].rd, tbl[i].data, tbl[i].word, tbl[i].exp_low,
                    tbl[i].exp_byte, tbl[i].exp_rsp, 0, $sformatf("vec%0d", i));
        check("slave_reg5", s_regs[5], 8'h01);
        check("slave_reg3", s_regs[3], 8'hA5);

        // cmd_valid held through a read: the repeat is taken only once GAP has elapsed.
        w  = $urandom;
        w2 = $urandom;
        run_cmd(1, 8'h00, w, frame_len(1), 8'h00, w, 1, "held_first");
        slave_word = w2;
        step();
        check("held_second_accepted", {bus.cmd_ready, bus.spi_cs_n}, 2'b00);
        bus.cmd_valid = 1'b0;
        t = 0;
        while (!bus.cmd_ready && t < 1000) begin step(); t++; end
        model_rsp = w2;
        check("held_second_gap", mon_last_gap, CS_GAP + 1);
        check("held_second_low", mon_low, frame_len(1));
        check("held_second_rsp", bus.rsp_data, model_rsp);

        for (int i = 0; i < 10; i++) begin
            rd = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            w  = $urandom;
            run_cmd(rd, d, w, frame_len(rd), d, w, 0, $sformatf("rand%0d", i));
        end

        // Reset lands in the middle of a read at bit 15.
        slave_word    = $urandom;
        slave_mode    = 1;
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        t = 0;
        while (mon_rises < 16 && t < 1000) begin step(); t++; end
        check("abort_reached_bit15", t < 1000, 1);
        rst_n = 1'b0;
        step();
        check("abort_outputs", {bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.cmd_ready,
                                bus.busy, bus.rsp_valid}, 6'b100100);
        check("abort_rsp_data", bus.rsp_data, 32'h0);
        repeat (4) step();
        check("abort_no_rsp", mon_rsp_pulses, 0);
        rst_n     = 1'b1;
        model_rsp = '0;
        step();
        run_cmd(0, 8'hFF, 32'h0, frame_len(0), 8'hFF, 32'h0, 0, "post_reset");

        check("busy_is_not_ready", mon_rb_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
